sa_acc_drain: RTL
=================

// Module: sa_acc_drain
// PURPOSE
//   Drain side of the PE accumulator interface: snapshots one row of INT32 PE acc_out values
//   and streams them out, one column per beat, on a valid/ready stream toward the output
//   buffer/DMA. Sits at the south edge of the systolic array, one instance per PE row.
//   Frees the PEs after a single-cycle snapshot, so they can start the next tile while the
//   drain serialises the previous one.
// PARAMETERS
//   N_COLS    4   PEs per row = accumulators per snapshot (>=2)
//   ACC_BITS  32  accumulator width, signed two's complement
//   COL_W     $clog2(N_COLS)  column index width (derived, localparam)
// PORTS
//   clk       in   1                clock, all logic on posedge
//   rstn      in   1                synchronous active-low reset
//   acc_vec   in   N_COLS*ACC_BITS  PE acc_out row; column c at [c*ACC_BITS +: ACC_BITS]
//   acc_vld   in   1                snapshot request (one-cycle strobe from array controller)
//   acc_rdy   out  1                drain idle, snapshot will be accepted
//   acc_clr   out  1                one-cycle pulse after an accepted snapshot: PEs may clear/reuse acc
//   m_data    out  ACC_BITS         output accumulator value
//   m_col     out  COL_W            column index of m_data
//   m_last    out  1                high on beat with m_col == N_COLS-1
//   m_valid   out  1                output beat valid
//   m_ready   in   1                downstream accepts beat
//   busy      out  1                snapshot held / draining
//   ovf       out  1                sticky: snapshot request dropped while busy
//   ovf_clr   in   1                clears ovf
// BEHAVIOUR
//   - Reset (rstn==0 at posedge): state=IDLE; acc_rdy=1 after reset; m_valid, m_last, acc_clr,
//     busy, ovf = 0; m_data, m_col = 0; snapshot bank = 0. Reset mid-drain drops the held row.
//   - FSM: IDLE -> DRAIN on acc_vld & acc_rdy; DRAIN -> IDLE on m_valid & m_ready & m_last.
//   - acc_rdy = (state==IDLE), combinational from state. busy = ~acc_rdy.
//   - Accept cycle: latch all N_COLS lanes of acc_vec, col=0. Next cycle: m_valid=1,
//     m_col=0, acc_clr=1 for exactly that cycle. Snapshot-to-first-beat latency = 1 cycle.
//   - Beat transfer on m_valid & m_ready: col+1; m_data/m_col/m_last update the same edge.
//   - m_valid & ~m_ready: m_data, m_col, m_last held stable; m_valid stays 1 (no retraction).
//   - Last beat accepted: m_valid=0 next cycle, acc_rdy=1 next cycle. A snapshot is
//     accepted no earlier than the cycle after the last beat (minimum N_COLS+1 cycles per row).
//   - acc_vld while ~acc_rdy: request ignored, held data untouched, ovf<=1.
//   - ovf_clr and a new drop in the same cycle: set wins, ovf stays 1.
//   - Column counter never wraps past N_COLS-1; m_last = (col==N_COLS-1).
//   - Values pass unmodified (bit-exact ACC_BITS) unless the optional feature below is enabled.
// CONFIGURATION
//   SA_DRAIN_RELU_EN defined: m_data = (lane<0) ? 0 : lane (ReLU fused on output path,
//   combinational from bank; no latency change). Undefined: m_data = lane, bit-exact.
// STRUCTURE
//   sa_pkg (shared): ACC_BITS_DEF=32, typedef logic signed [ACC_BITS_DEF-1:0] acc_t,
//   typedef enum logic {DRAIN_IDLE, DRAIN_BUSY} drain_state_e.
//   Single module, no sub-module: snapshot bank (acc_t [N_COLS]), column counter,
//   2-state FSM, output mux, optional ReLU.
// TESTING  (N_COLS=4, ACC_BITS=32)
//   1 acc_vec={-5,300,0,7} (col3..0), acc_vld 1 cycle, m_ready=1 -> beats col0..3 =
//     7,0,300,-5 on 4 consecutive cycles from accept+1; m_last only on col3; acc_clr 1 pulse;
//     acc_rdy back 1 cycle after last beat.
//   2 Same row, m_ready toggles 1,0,0,1,... -> m_data/m_col stable across stall, no beat
//     lost or duplicated, order 0..3.
//   3 acc_vld again at col1 with acc_vec={9,9,9,9} -> ignored, ovf=1, drained values still
//     original; ovf_clr pulse -> ovf=0; ovf_clr with simultaneous drop -> ovf stays 1.
//   4 rstn=0 for 1 cycle at col2 -> next cycle m_valid=0, acc_rdy=1, ovf=0; new snapshot
//     {1,2,3,4} drains 4,3,2,1 from col0.
//   5 Back-to-back: acc_vld held high, m_ready=1 -> rows accepted every 5 cycles, no ovf
//     on the accepted cycles; ovf set on the blocked cycles.
//   6 SA_DRAIN_RELU_EN: row {-5,300,-2147483648,7} -> 7,0,300,0; without macro -> 7,
//     -2147483648,300,-5 bit-exact.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared systolic-array types: default accumulator width, accumulator type and
// the drain FSM state encoding.
package sa_pkg;

    localparam int ACC_BITS_DEF = 32;

    typedef logic signed [ACC_BITS_DEF-1:0] acc_t;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_BUSY
    } drain_state_e;

endpackage

// File: rtl/sa_acc_drain.sv
// Accumulator row drain: snapshots one row of PE accumulators in a single cycle and
// streams it out column by column. Optional macro SA_DRAIN_RELU_EN fuses ReLU on m_data.
module sa_acc_drain
    import sa_pkg::*;
#(
    parameter  int N_COLS   = 4,
    parameter  int ACC_BITS = ACC_BITS_DEF,
    localparam int COL_W    = $clog2(N_COLS)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N_COLS*ACC_BITS-1:0] acc_vec,
    input  logic                       acc_vld,
    output logic                       acc_rdy,
    output logic                       acc_clr,
    output logic [ACC_BITS-1:0]        m_data,
    output logic [COL_W-1:0]           m_col,
    output logic                       m_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       busy,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);

    drain_state_e               r_state;
    logic signed [ACC_BITS-1:0] r_bank [N_COLS];
    logic [COL_W-1:0]           r_col;
    logic                       r_acc_clr;
    logic                       r_ovf;

    logic signed [ACC_BITS-1:0] w_snap [N_COLS];
    logic signed [ACC_BITS-1:0] w_lane;
    logic                       w_idle;
    logic                       w_accept;
    logic                       w_drop;
    logic                       w_at_last;

    for (genvar g = 0; g < N_COLS; g++) begin : g_lane
        assign w_snap[g] = acc_vec[g*ACC_BITS +: ACC_BITS];
    end

    assign w_idle    = (r_state == DRAIN_IDLE);
    assign w_accept  = acc_vld & w_idle;
    assign w_drop    = acc_vld & ~w_idle;
    assign w_at_last = (r_col == LAST_COL);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= DRAIN_IDLE;
            r_bank    <= '{default: '0};
            r_col     <= '0;
            r_acc_clr <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_acc_clr <= w_accept;
            // A drop in the same cycle as ovf_clr keeps the flag set.
            if (w_drop)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;

            case (r_state)
                DRAIN_IDLE: begin
                    if (acc_vld) begin
                        r_bank  <= w_snap;
                        r_col   <= '0;
                        r_state <= DRAIN_BUSY;
                    end
                end
                DRAIN_BUSY: begin
                    if (m_ready) begin
                        if (w_at_last)
                            r_state <= DRAIN_IDLE;
                        else
                            r_col <= r_col + 1'b1;
                    end
                end
                default: r_state <= DRAIN_IDLE;
            endcase
        end
    end

    assign w_lane = r_bank[r_col];

`ifdef SA_DRAIN_RELU_EN
    assign m_data = w_lane[ACC_BITS-1] ? '0 : w_lane;
`else
    assign m_data = w_lane;
`endif

    assign acc_rdy = w_idle;
    assign busy    = ~w_idle;
    assign m_valid = ~w_idle;
    assign m_col   = r_col;
    assign m_last  = ~w_idle & w_at_last;
    assign acc_clr = r_acc_clr;
    assign ovf     = r_ovf;

endmodule
